// File: rtl/delay_pkg.sv
// Shared constants and width helpers for the delay stage and its output FIFO.
package delay_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Pointer width for a power-of-two depth; at least one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width; must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_out_fifo_ram.sv
// Storage array for delay_out_fifo: one synchronous write port, asynchronous read.
module delay_out_fifo_ram
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_out_fifo.sv
// First-word-fall-through FIFO buffering the delay stage output.
// Optional occupancy port enabled by defining DELAY_OUT_FIFO_COUNT_EN.
module delay_out_fifo
  import delay_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             afull,
  output logic             full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             overflow
`ifdef DELAY_OUT_FIFO_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] count
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wr_en;
  logic          rd_en;
  logic          drop;

  // Status flags decode occupancy only, so upstream sees no path from its own valid.
  assign full      = (cnt_q == FULL_LVL);
  assign afull     = (cnt_q >= AFULL_LVL);
  assign out_valid = (cnt_q != '0);

  // A full FIFO drops the write even when a read frees a slot on the same edge.
  assign wr_en = in_valid && !full;
  assign rd_en = out_valid && out_ready;
  assign drop  = in_valid && full;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt_q <= cnt_d;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  delay_out_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

`ifdef DELAY_OUT_FIFO_COUNT_EN
  assign count = cnt_q;
`endif

endmodule

// File: tb/tb_delay_out_fifo.sv
// Self-checking bench for delay_out_fifo against a queue-based reference model.
module tb_delay_out_fifo;

  localparam int unsigned WIDTH        = 8;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned AFULL_MARGIN = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             afull;
  logic             full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             overflow;
`ifdef DELAY_OUT_FIFO_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf = 1'b0;

  delay_out_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .afull     (afull),
    .full      (full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef DELAY_OUT_FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ideal bounded queue updated once per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      bit do_wr;
      bit do_rd;
      do_wr = (in_valid === 1'b1) && (model_q.size() < DEPTH);
      do_rd = (out_ready === 1'b1) && (model_q.size() > 0);
      if ((in_valid === 1'b1) && (model_q.size() == DEPTH)) model_ovf = 1'b1;
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(in_data);
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    if (n != 0) chk("out_data", 32'(out_data), 32'(model_q[0]));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("afull", 32'(afull), 32'((DEPTH - n) <= AFULL_MARGIN));
    chk("overflow", 32'(overflow), 32'(model_ovf));
`ifdef DELAY_OUT_FIFO_COUNT_EN
    chk("count", 32'(count), 32'(n));
`endif
  end

  // Apply inputs for one cycle; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    do_reset();

    // Fill with 0x01..0x08, no reads.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 3) chk("afull_after3", 32'(afull), 32'd0);
      if (i == 4) chk("afull_after4", 32'(afull), 32'd1);
      if (i == 7) chk("full_after7", 32'(full), 32'd0);
    end
    chk("full_after8", 32'(full), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd0);
    chk("fill_head", 32'(out_data), 32'h01);

    // Write while full with a simultaneous read: 0x01 leaves, 0xAA is dropped.
    cyc(1'b1, 8'hAA, 1'b1);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_full", 32'(full), 32'd0);
    chk("drop_head", 32'(out_data), 32'h02);
    for (int i = 2; i <= 8; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Single write into an empty FIFO appears one cycle later.
    in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
    #2;
    chk("no_comb_path", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data", 32'(out_data), 32'h5C);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_drained", 32'(out_valid), 32'd0);

    // Steady state at occupancy 3 with concurrent read and write.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("steady_data", 32'(out_data), 32'(8'h10 + i));
      cyc(1'b1, 8'(8'h13 + i), 1'b1);
      chk("steady_afull", 32'(afull), 32'd0);
    end

    // Asynchronous reset mid-burst at occupancy 5.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 8'h77, 1'b0);
    chk("post_rst_first", 32'(out_data), 32'h77);
    cyc(1'b0, 8'h00, 1'b1);

    // Random traffic with upstream throttled by afull.
    for (int i = 0; i < 1000; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0) && !afull;
      cyc(v, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    chk("random_overflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/delay_out_fifo.md
DELAY_OUT_FIFO -- requirements
Module: delay_out_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, storage entries; power of 2, >= 2.
REQ-003 SHALL have parameter AFULL_MARGIN, default 4, free-slot threshold for afull; 0 <= AFULL_MARGIN < DEPTH.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, in_data is a valid word this cycle (driven from the upstream delay stage's enable/valid).
REQ-007 SHALL have port in_data, input, WIDTH, write data (the upstream delay stage's data_out).
REQ-008 SHALL have port afull, output, 1, free slots <= AFULL_MARGIN; upstream deasserts its en.
REQ-009 SHALL have port full, output, 1, count == DEPTH.
REQ-010 SHALL have port out_valid, output, 1, out_data holds the oldest stored word.
REQ-011 SHALL have port out_data, output, WIDTH, oldest stored word, first-word-fall-through.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when a write is dropped.

Function
REQ-014 Write SHALL occur on a clock edge where in_valid && !full; in_data stored at wr_ptr, wr_ptr += 1 modulo DEPTH.
REQ-015 Read SHALL occur on a clock edge where out_valid && out_ready; rd_ptr += 1 modulo DEPTH.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL equal mem[rd_ptr] combinationally; out_data is don't-care when !out_valid.
REQ-017 Write-to-out_valid latency SHALL be 1 cycle when empty; no combinational path from in_* to out_*.
REQ-018 Simultaneous read and write with 0 < count < DEPTH SHALL leave count unchanged, both pointers advancing.
REQ-019 When full, in_valid SHALL be dropped even if a read occurs that edge; overflow set to 1 and held until reset.
REQ-020 When empty, out_ready SHALL have no effect.
REQ-021 count SHALL be $clog2(DEPTH+1) bits; pointers $clog2(DEPTH) bits, wrapping naturally.
REQ-022 full and afull SHALL be registered-state-derived (decode of count only), never from in_valid or out_ready.
REQ-023 Word order at out_data SHALL match in_data acceptance order exactly; no word duplicated or lost except per REQ-019.

Reset
REQ-024 rst SHALL asynchronously clear wr_ptr, rd_ptr, count, overflow to 0.
REQ-025 During and after reset: out_valid=0, full=0, overflow=0, afull=(DEPTH <= AFULL_MARGIN) i.e. 0 for legal parameters.
REQ-026 Reset mid-operation SHALL discard all stored words; memory array itself not reset.

Configuration
REQ-027 Macro DELAY_OUT_FIFO_COUNT_EN defined SHALL add output port count, width $clog2(DEPTH+1), equal to current occupancy.
REQ-028 Macro DELAY_OUT_FIFO_COUNT_EN undefined SHALL omit the count port; all other behaviour identical.

Structure
REQ-029 Shared package delay_pkg SHALL hold the ptr/count width helper functions and the default WIDTH constant used by delay and delay_out_fifo.
REQ-030 Storage SHALL be one sub-module, delay_out_fifo_ram (1 write port, asynchronous read), instantiated once.

Verification
REQ-031 Reset then 8 writes 0x01..0x08 with out_ready=0 -> full=1 after 8th edge, afull=1 after 4th edge, overflow=0.
REQ-032 Full FIFO, in_valid=1 data 0xAA with out_ready=1 -> 0x01 read, 0xAA dropped, overflow=1 sticky until rst.
REQ-033 Empty, single write 0x5C -> out_valid=1 and out_data=0x5C exactly one cycle later.
REQ-034 Count=3, in_valid=1 and out_ready=1 for 20 cycles -> count stays 3, output sequence equals input sequence delayed by 3 accepts.
REQ-035 rst asserted mid-burst at count=5 -> out_valid=0 immediately (asynchronous), count=0 after release, next write appears as first output.
REQ-036 1000 cycles random in_valid/out_ready with in_valid gated by !afull -> queue reference model matches every accepted read, overflow never set.
